lc3_pipe_controller: RTL and testbench

- Central sequencer for the LC3 five-stage pipeline.
- Generates the stage enables: update-PC, fetch, decode latch, execute, writeback.
- Runs the data-memory access state machine and the branch-flush bubble logic.
- Detects ALU result bypass between the execute stage and the instruction leaving the decode latch (ir / npc_out bus).

---
 rtl/lc3_pipe_controller.sv | 155 +++++++++++++++
 tb/tb_lc3_pipe_controller.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_pipe_controller.sv
// ============================================================================
// Module   : lc3_pipe_controller
// Purpose  : LC3 five-stage pipeline sequencer: stage enables, data-memory
//            access FSM, branch-flush bubbles and ALU bypass detection.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lc3_pipe_controller #(
   parameter int FLUSH_CYCLES = 2,
   parameter int FILL_CYCLES  = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] ir,
   input  logic [15:0] ir_exec,
   input  logic [2:0]  psr,
   input  logic        complete_data,
   output logic        enable_updatePC,
   output logic        enable_fetch,
   output logic        enable_decode,
   output logic        enable_execute,
   output logic        enable_writeback,
   output logic        br_taken,
   output logic [1:0]  mem_state,
   output logic        bypass_alu_1,
   output logic        bypass_alu_2
);

   typedef enum logic [1:0] {
      MEM_READ     = 2'd0,
      MEM_INDIRECT = 2'd1,
      MEM_WRITE    = 2'd2,
      MEM_IDLE     = 2'd3
   } mem_state_t;

   localparam logic [3:0] c_OP_BR  = 4'd0;
   localparam logic [3:0] c_OP_ADD = 4'd1;
   localparam logic [3:0] c_OP_LD  = 4'd2;
   localparam logic [3:0] c_OP_ST  = 4'd3;
   localparam logic [3:0] c_OP_AND = 4'd5;
   localparam logic [3:0] c_OP_LDR = 4'd6;
   localparam logic [3:0] c_OP_STR = 4'd7;
   localparam logic [3:0] c_OP_NOT = 4'd9;
   localparam logic [3:0] c_OP_LDI = 4'd10;
   localparam logic [3:0] c_OP_STI = 4'd11;
   localparam logic [3:0] c_OP_JMP = 4'd12;

   localparam logic [2:0] c_FILL  = 3'(FILL_CYCLES);
   localparam logic [1:0] c_FLUSH = 2'(FLUSH_CYCLES);

   mem_state_t r_state;
   mem_state_t w_state_nxt;
   logic       r_load;
   logic       w_load_nxt;
   logic [2:0] r_fill;
   logic [1:0] r_flush;

   logic [3:0] w_op_x;
   logic [3:0] w_op_d;
   logic       w_is_load;
   logic       w_is_store;
   logic       w_is_ind;
   logic       w_alu_x;
   logic       w_alu_d;
   logic       w_fill_done;
   logic       w_br_cond;
   logic       w_unused;

   assign w_op_x     = ir_exec[15:12];
   assign w_op_d     = ir[15:12];
   assign w_is_load  = (w_op_x == c_OP_LD) || (w_op_x == c_OP_LDR) || (w_op_x == c_OP_LDI);
   assign w_is_store = (w_op_x == c_OP_ST) || (w_op_x == c_OP_STR) || (w_op_x == c_OP_STI);
   assign w_is_ind   = (w_op_x == c_OP_LDI) || (w_op_x == c_OP_STI);
   assign w_alu_x    = (w_op_x == c_OP_ADD) || (w_op_x == c_OP_AND) || (w_op_x == c_OP_NOT);
   assign w_alu_d    = (w_op_d == c_OP_ADD) || (w_op_d == c_OP_AND) || (w_op_d == c_OP_NOT);
   assign w_fill_done = (r_fill == c_FILL);
   assign w_br_cond  = (w_op_x == c_OP_JMP) ||
                       ((w_op_x == c_OP_BR) && ((ir_exec[11:9] & psr) != 3'b000));
   assign w_unused   = ^{ir[11:9], ir[4:3], ir_exec[8:0]};
   assign mem_state  = r_state;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= MEM_IDLE;
         r_load  <= 1'b0;
         r_fill  <= 3'd0;
         r_flush <= 2'd0;
      end else begin
         r_state <= w_state_nxt;
         r_load  <= w_load_nxt;
         if (r_fill < c_FILL)
            r_fill <= r_fill + 3'd1;
         if (br_taken)
            r_flush <= c_FLUSH;
         else if (r_flush != 2'd0)
            r_flush <= r_flush - 2'd1;
      end
   end

   always_comb begin
      // Fill ramp: a short FILL_CYCLES turns the remaining stages on together.
      enable_updatePC  = (r_fill != 3'd0);
      enable_fetch     = (r_fill != 3'd0);
      enable_decode    = (r_fill >= 3'd2) || w_fill_done;
      enable_execute   = (r_fill >= 3'd3) || w_fill_done;
      enable_writeback = (r_fill >= 3'd4) || w_fill_done;
      w_state_nxt      = r_state;
      w_load_nxt       = r_load;

      if (r_state != MEM_IDLE) begin
         enable_updatePC  = 1'b0;
         enable_fetch     = 1'b0;
         enable_decode    = 1'b0;
         enable_execute   = 1'b0;
         enable_writeback = (r_state == MEM_READ) && complete_data && r_load;
      end else if (r_flush != 2'd0) begin
         enable_decode    = 1'b0;
         enable_execute   = 1'b0;
         enable_writeback = 1'b0;
      end

      case (r_state)
         MEM_IDLE: begin
            if (enable_execute && (w_is_load || w_is_store)) begin
               w_load_nxt = w_is_load;
               if (w_is_ind)
                  w_state_nxt = MEM_INDIRECT;
               else if (w_is_load)
                  w_state_nxt = MEM_READ;
               else
                  w_state_nxt = MEM_WRITE;
            end
         end
         MEM_INDIRECT: begin
            if (complete_data)
               w_state_nxt = r_load ? MEM_READ : MEM_WRITE;
         end
         MEM_READ, MEM_WRITE: begin
            if (complete_data)
               w_state_nxt = MEM_IDLE;
         end
         default: w_state_nxt = MEM_IDLE;
      endcase

      // enable_execute already folds in the memory-stall and flush gating.
      br_taken     = enable_execute && w_br_cond;
      bypass_alu_1 = enable_execute && w_alu_x && w_alu_d && (ir[8:6] == ir_exec[11:9]);
      bypass_alu_2 = enable_execute && w_alu_x && w_alu_d && (w_op_d != c_OP_NOT) &&
                     !ir[5] && (ir[2:0] == ir_exec[11:9]);
   end

endmodule

`default_nettype wire

// File: tb/tb_lc3_pipe_controller.sv
// ============================================================================
// Module   : tb_lc3_pipe_controller
// Purpose  : Self-checking bench: directed scenarios plus randomized traffic
//            against a queue-based behavioural model of the pipeline control.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lc3_pipe_controller;

   localparam int FLUSH = 2;
   localparam int FILL  = 4;
   localparam logic [15:0] ALU_X = 16'h1262;
   localparam logic [15:0] ALU_D = 16'h5000;

   logic        clock = 1'b0;
   logic        reset;
   logic [15:0] ir;
   logic [15:0] ir_exec;
   logic [2:0]  psr;
   logic        complete_data;
   logic        enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback;
   logic        br_taken;
   logic [1:0]  mem_state;
   logic        bypass_alu_1, bypass_alu_2;

   int checks   = 0;
   int failures = 0;

   // Model: cycles since reset release, remaining bubble cycles, and the list
   // of memory states still to be visited by the current access.
   int m_since = 0;
   int m_flush = 0;
   int m_memq[$];
   bit e_exe, e_br;

   always #5 clock = ~clock;

   lc3_pipe_controller #(.FLUSH_CYCLES(FLUSH), .FILL_CYCLES(FILL)) dut (
      .clock(clock), .reset(reset), .ir(ir), .ir_exec(ir_exec), .psr(psr),
      .complete_data(complete_data),
      .enable_updatePC(enable_updatePC), .enable_fetch(enable_fetch),
      .enable_decode(enable_decode), .enable_execute(enable_execute),
      .enable_writeback(enable_writeback), .br_taken(br_taken), .mem_state(mem_state),
      .bypass_alu_1(bypass_alu_1), .bypass_alu_2(bypass_alu_2)
   );

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit is_alu(input logic [3:0] op);
      return (op == 4'd1) || (op == 4'd5) || (op == 4'd9);
   endfunction

   task automatic apply(input logic rn, input logic [15:0] a_ir, input logic [15:0] a_ix,
                        input logic [2:0] a_psr, input logic a_cd);
      bit pc, fe, de, ex, wb, br, b1, b2, alu_pair;
      int st;
      logic [3:0] opx, opd;
      @(negedge clock);
      reset = rn; ir = a_ir; ir_exec = a_ix; psr = a_psr; complete_data = a_cd;
      #1;
      opx = a_ix[15:12];
      opd = a_ir[15:12];
      st = 3;
      pc = 0; fe = 0; de = 0; ex = 0; wb = 0;
      if (rn) begin
         pc = (m_since >= 1);
         fe = pc;
         de = (m_since >= 2) || (m_since >= FILL);
         ex = (m_since >= 3) || (m_since >= FILL);
         wb = (m_since >= 4) || (m_since >= FILL);
         if (m_memq.size() != 0) begin
            st = m_memq[0];
            pc = 0; fe = 0; de = 0; ex = 0;
            wb = (st == 0) && a_cd;
         end else if (m_flush > 0) begin
            de = 0; ex = 0; wb = 0;
         end
      end
      br = ex && ((opx == 4'd12) || ((opx == 4'd0) && ((a_ix[11:9] & a_psr) != 3'b000)));
      alu_pair = ex && is_alu(opx) && is_alu(opd);
      b1 = alu_pair && (a_ir[8:6] == a_ix[11:9]);
      b2 = alu_pair && (opd != 4'd9) && !a_ir[5] && (a_ir[2:0] == a_ix[11:9]);
      e_exe = ex;
      e_br  = br;
      chk("enable_updatePC", {15'd0, enable_updatePC}, {15'd0, pc});
      chk("enable_fetch", {15'd0, enable_fetch}, {15'd0, fe});
      chk("enable_decode", {15'd0, enable_decode}, {15'd0, de});
      chk("enable_execute", {15'd0, enable_execute}, {15'd0, ex});
      chk("enable_writeback", {15'd0, enable_writeback}, {15'd0, wb});
      chk("br_taken", {15'd0, br_taken}, {15'd0, br});
      chk("mem_state", {14'd0, mem_state}, 16'(st));
      chk("bypass_alu_1", {15'd0, bypass_alu_1}, {15'd0, b1});
      chk("bypass_alu_2", {15'd0, bypass_alu_2}, {15'd0, b2});
   endtask

   task automatic tick();
      logic [3:0] opx;
      @(posedge clock);
      opx = ir_exec[15:12];
      if (!reset) begin
         m_since = 0;
         m_flush = 0;
         m_memq.delete();
      end else begin
         if (m_memq.size() != 0) begin
            if (complete_data) void'(m_memq.pop_front());
         end else if (e_exe) begin
            case (opx)
               4'd2, 4'd6: m_memq = '{0};
               4'd3, 4'd7: m_memq = '{2};
               4'd10:      m_memq = '{1, 0};
               4'd11:      m_memq = '{1, 2};
               default: ;
            endcase
         end
         if (e_br) m_flush = FLUSH;
         else if (m_flush > 0) m_flush--;
         if (m_since < FILL) m_since++;
      end
   endtask

   task automatic step(input logic rn, input logic [15:0] a_ir, input logic [15:0] a_ix,
                       input logic [2:0] a_psr, input logic a_cd);
      apply(rn, a_ir, a_ix, a_psr, a_cd);
      tick();
   endtask

   initial begin
      int ops[11] = '{0, 1, 2, 3, 5, 6, 7, 9, 10, 11, 12};
      int alus[3] = '{1, 5, 9};
      reset = 1'b0; ir = ALU_D; ir_exec = ALU_X; psr = 3'b000; complete_data = 1'b0;

      // Reset and pipeline fill
      apply(0, ALU_D, ALU_X, 3'b000, 0);
      chk("rst_pc", {15'd0, enable_updatePC}, 16'd0);
      chk("rst_mem", {14'd0, mem_state}, 16'd3);
      tick();
      apply(1, ALU_D, ALU_X, 3'b000, 0);
      chk("fill0_fetch", {15'd0, enable_fetch}, 16'd0);
      tick();
      apply(1, ALU_D, ALU_X, 3'b000, 0);
      chk("fill1_fetch", {15'd0, enable_fetch}, 16'd1);
      chk("fill1_decode", {15'd0, enable_decode}, 16'd0);
      tick();
      apply(1, ALU_D, ALU_X, 3'b000, 0);
      chk("fill2_decode", {15'd0, enable_decode}, 16'd1);
      chk("fill2_exec", {15'd0, enable_execute}, 16'd0);
      tick();
      step(1, ALU_D, ALU_X, 3'b000, 0);
      apply(1, ALU_D, ALU_X, 3'b000, 0);
      chk("fill4_wb", {15'd0, enable_writeback}, 16'd1);
      tick();

      // LD with completion on the second READ cycle
      step(1, ALU_D, 16'h2A05, 3'b000, 0);
      apply(1, ALU_D, 16'h2A05, 3'b000, 0);
      chk("ld_state", {14'd0, mem_state}, 16'd0);
      chk("ld_fetch", {15'd0, enable_fetch}, 16'd0);
      chk("ld_wb_wait", {15'd0, enable_writeback}, 16'd0);
      tick();
      apply(1, ALU_D, 16'h2A05, 3'b000, 1);
      chk("ld_wb_done", {15'd0, enable_writeback}, 16'd1);
      tick();
      apply(1, ALU_D, ALU_X, 3'b000, 0);
      chk("ld_idle", {14'd0, mem_state}, 16'd3);
      tick();

      // LDI through INDIRECT then READ
      step(1, ALU_D, 16'hA405, 3'b000, 0);
      apply(1, ALU_D, 16'hA405, 3'b000, 1);
      chk("ldi_ind", {14'd0, mem_state}, 16'd1);
      chk("ldi_ind_pc", {15'd0, enable_updatePC}, 16'd0);
      tick();
      apply(1, ALU_D, 16'hA405, 3'b000, 0);
      chk("ldi_read", {14'd0, mem_state}, 16'd0);
      tick();
      step(1, ALU_D, 16'hA405, 3'b000, 1);
      step(1, ALU_D, ALU_X, 3'b000, 0);

      // Taken branch then a never-taken BR
      apply(1, ALU_D, 16'h0E03, 3'b010, 0);
      chk("br_pulse", {15'd0, br_taken}, 16'd1);
      tick();
      apply(1, ALU_D, ALU_X, 3'b000, 0);
      chk("flush_decode", {15'd0, enable_decode}, 16'd0);
      chk("flush_fetch", {15'd0, enable_fetch}, 16'd1);
      tick();
      step(1, ALU_D, ALU_X, 3'b000, 0);
      apply(1, ALU_D, ALU_X, 3'b000, 0);
      chk("flush_over", {15'd0, enable_decode}, 16'd1);
      tick();
      apply(1, ALU_D, 16'h0003, 3'b010, 0);
      chk("br_false", {15'd0, br_taken}, 16'd0);
      tick();
      step(1, ALU_D, ALU_X, 3'b000, 0);

      // Bypass detection
      apply(1, 16'h1441, 16'h1262, 3'b000, 0);
      chk("byp_add_1", {15'd0, bypass_alu_1}, 16'd1);
      chk("byp_add_2", {15'd0, bypass_alu_2}, 16'd1);
      tick();
      apply(1, 16'h147F, 16'h1262, 3'b000, 0);
      chk("byp_imm_1", {15'd0, bypass_alu_1}, 16'd1);
      chk("byp_imm_2", {15'd0, bypass_alu_2}, 16'd0);
      tick();
      step(1, 16'h9A7F, 16'h1E62, 3'b000, 0);

      // Asynchronous reset in INDIRECT
      step(1, ALU_D, 16'hA405, 3'b000, 0);
      apply(1, ALU_D, 16'hA405, 3'b000, 0);
      chk("ind_before_rst", {14'd0, mem_state}, 16'd1);
      #2 reset = 1'b0;
      #1;
      chk("async_mem", {14'd0, mem_state}, 16'd3);
      chk("async_wb", {15'd0, enable_writeback}, 16'd0);
      chk("async_pc", {15'd0, enable_updatePC}, 16'd0);
      tick();
      step(0, ALU_D, ALU_X, 3'b000, 0);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         logic [15:0] rix, rir;
         logic rn;
         rix = {4'(ops[$urandom_range(0, 10)]), 12'($urandom)};
         if ($urandom_range(0, 3) == 0)
            rir = 16'($urandom);
         else
            rir = {4'(alus[$urandom_range(0, 2)]), 12'($urandom)};
         rn = ($urandom_range(0, 199) != 0);
         step(rn, rir, rix, 3'($urandom), ($urandom_range(0, 2) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
